// File: rtl/sid_tick_gen_if.sv
// Control/status bundle between a SID clock-enable generator and its host.
// The generator connects as slave; the host side (or a bench) uses master.
interface sid_tick_gen_if;
  logic en;
  logic sel_ntsc;
  logic soft_rst;
  logic sid_ce;
  logic sid_phi2;
  logic sample_ce;
  logic sid_rst;
  logic ntsc_active;

  modport master (
    output en, sel_ntsc, soft_rst,
    input  sid_ce, sid_phi2, sample_ce, sid_rst, ntsc_active
  );

  modport slave (
    input  en, sel_ntsc, soft_rst,
    output sid_ce, sid_phi2, sample_ce, sid_rst, ntsc_active
  );
endinterface

// File: rtl/sid_tick_gen.sv
// SID core clock-enable generator: phase accumulator from the 48 MHz clock,
// phi2 level, audio sample enable and a tick-counted SID-domain reset.
module sid_tick_gen #(
  parameter int ACC_W      = 24,
  parameter int INC_PAL    = 344369,
  parameter int INC_NTSC   = 357955,
  parameter int SAMPLE_DIV = 22,
  parameter int RST_TICKS  = 32
) (
  input  logic            clk_i,
  input  logic            rst_in,
  sid_tick_gen_if.slave   bus
);

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] INC_PAL_V   = ACC_W'(INC_PAL);
  localparam logic [ACC_W-1:0] INC_NTSC_V  = ACC_W'(INC_NTSC);
  localparam logic [7:0]       RST_LAST    = 8'(RST_TICKS - 1);
  localparam logic [7:0]       SAMPLE_LAST = 8'(SAMPLE_DIV - 1);

  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [ACC_W-1:0] inc_reg, inc_next;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             ntsc_reg, ntsc_next;
  logic             sel_meta_reg, sel_s_reg;
  logic             sid_ce_reg;
  logic             phi2_reg;
  logic             sample_ce_reg, sample_ce_next;
  state_t           state_reg, state_next;
  logic [7:0]       rst_cnt_reg, rst_cnt_next;
  logic [7:0]       sample_cnt_reg, sample_cnt_next;

  // Accumulator keeps its remainder on overflow; the rate only switches on a
  // carry so a tick period is never cut or stretched by a rate change.
  always_comb begin
    sum       = {1'b0, acc_reg} + {1'b0, inc_reg};
    carry     = bus.en & sum[ACC_W];
    acc_next  = bus.en ? sum[ACC_W-1:0] : acc_reg;
    inc_next  = inc_reg;
    ntsc_next = ntsc_reg;
    if (carry) begin
      inc_next  = sel_s_reg ? INC_NTSC_V : INC_PAL_V;
      ntsc_next = sel_s_reg;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rst_cnt_next    = rst_cnt_reg;
    sample_cnt_next = sample_cnt_reg;
    sample_ce_next  = 1'b0;
    case (state_reg)
      ST_HOLD: begin
        sample_cnt_next = '0;
        // A restart request beats a coincident releasing tick.
        if (bus.soft_rst) begin
          rst_cnt_next = '0;
        end else if (carry) begin
          if (rst_cnt_reg == RST_LAST) begin
            state_next   = ST_RUN;
            rst_cnt_next = '0;
          end else begin
            rst_cnt_next = rst_cnt_reg + 8'd1;
          end
        end
      end
      ST_RUN: begin
        if (bus.soft_rst) begin
          state_next      = ST_HOLD;
          rst_cnt_next    = '0;
          sample_cnt_next = '0;
        end else if (carry) begin
          if (sample_cnt_reg == SAMPLE_LAST) begin
            sample_cnt_next = '0;
            sample_ce_next  = 1'b1;
          end else begin
            sample_cnt_next = sample_cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_in) begin
    if (rst_in) begin
      acc_reg        <= '0;
      inc_reg        <= INC_PAL_V;
      ntsc_reg       <= 1'b0;
      sel_meta_reg   <= 1'b0;
      sel_s_reg      <= 1'b0;
      sid_ce_reg     <= 1'b0;
      phi2_reg       <= 1'b0;
      sample_ce_reg  <= 1'b0;
      state_reg      <= ST_HOLD;
      rst_cnt_reg    <= '0;
      sample_cnt_reg <= '0;
    end else begin
      acc_reg        <= acc_next;
      inc_reg        <= inc_next;
      ntsc_reg       <= ntsc_next;
      sel_meta_reg   <= bus.sel_ntsc;
      sel_s_reg      <= sel_meta_reg;
      sid_ce_reg     <= carry;
      phi2_reg       <= phi2_reg ^ carry;
      sample_ce_reg  <= sample_ce_next;
      state_reg      <= state_next;
      rst_cnt_reg    <= rst_cnt_next;
      sample_cnt_reg <= sample_cnt_next;
    end
  end

  assign bus.sid_ce      = sid_ce_reg;
  assign bus.sid_phi2    = phi2_reg;
  assign bus.sample_ce   = sample_ce_reg;
  assign bus.sid_rst     = (state_reg == ST_HOLD);
  assign bus.ntsc_active = ntsc_reg;

endmodule

// File: tb/tb_sid_tick_gen.sv
// Bench for sid_tick_gen: per-cycle scoreboard against a behavioural model,
// plus directed timing checks on recorded output history.
module tb_sid_tick_gen;

  localparam int ACC_W      = 8;
  localparam int INC_PAL    = 64;
  localparam int INC_NTSC   = 96;
  localparam int SAMPLE_DIV = 3;
  localparam int RST_TICKS  = 2;
  localparam int HIST_N     = 1024;

  logic clk_i  = 1'b0;
  logic rst_in = 1'b1;

  sid_tick_gen_if bus();

  sid_tick_gen #(
    .ACC_W(ACC_W), .INC_PAL(INC_PAL), .INC_NTSC(INC_NTSC),
    .SAMPLE_DIV(SAMPLE_DIV), .RST_TICKS(RST_TICKS)
  ) dut (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bad_sce  = 0;

  // Expected {sid_ce, sid_phi2, sample_ce, sid_rst, ntsc_active} per negedge.
  logic [4:0] exp_q[$];
  logic hist_ce[HIST_N];
  logic hist_sce[HIST_N];
  logic hist_rst[HIST_N];
  logic hist_ntsc[HIST_N];

  int m_acc, m_inc, m_rcnt, m_scnt;
  bit m_ntsc, m_meta, m_sel, m_ce, m_phi, m_sce, m_hold;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_inc = INC_PAL; m_ntsc = 0; m_meta = 0; m_sel = 0;
    m_ce = 0; m_phi = 0; m_sce = 0; m_hold = 1; m_rcnt = 0; m_scnt = 0;
  endtask

  function automatic logic [4:0] model_out();
    return {m_ce, m_phi, m_sce, m_hold, m_ntsc};
  endfunction

  // State after the next rising edge, given the inputs applied before it.
  task automatic model_step(input logic e, input logic s, input logic sr);
    int sum;
    bit c;
    sum = m_acc + m_inc;
    c = e && (sum >= (1 << ACC_W));
    if (e) m_acc = sum % (1 << ACC_W);
    if (c) begin
      m_inc  = m_sel ? INC_NTSC : INC_PAL;
      m_ntsc = m_sel;
    end
    m_sel = m_meta;
    m_meta = s;
    m_ce = c;
    m_phi = m_phi ^ c;
    m_sce = 0;
    if (m_hold) begin
      m_scnt = 0;
      if (sr) m_rcnt = 0;
      else if (c) begin
        if (m_rcnt == RST_TICKS - 1) begin m_hold = 0; m_rcnt = 0; end
        else m_rcnt++;
      end
    end else begin
      if (sr) begin m_hold = 1; m_rcnt = 0; m_scnt = 0; end
      else if (c) begin
        if (m_scnt == SAMPLE_DIV - 1) begin m_scnt = 0; m_sce = 1; end
        else m_scnt++;
      end
    end
  endtask

  task automatic cycle(input logic e, input logic s, input logic sr);
    logic [4:0] exp_v;
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      check_eq("sid_ce",      bus.sid_ce,      exp_v[4]);
      check_eq("sid_phi2",    bus.sid_phi2,    exp_v[3]);
      check_eq("sample_ce",   bus.sample_ce,   exp_v[2]);
      check_eq("sid_rst",     bus.sid_rst,     exp_v[1]);
      check_eq("ntsc_active", bus.ntsc_active, exp_v[0]);
    end
    if (bus.sample_ce === 1'b1 && (bus.sid_rst !== 1'b0 || bus.sid_ce !== 1'b1)) bad_sce++;
    hist_ce[cyc]   = bus.sid_ce;
    hist_sce[cyc]  = bus.sample_ce;
    hist_rst[cyc]  = bus.sid_rst;
    hist_ntsc[cyc] = bus.ntsc_active;
    rst_in = 1'b0;
    bus.en = e;
    bus.sel_ntsc = s;
    bus.soft_rst = sr;
    model_step(e, s, sr);
    exp_q.push_back(model_out());
    cyc++;
  endtask

  function automatic int next_after(input int c, input bit smp);
    for (int i = c + 1; i < cyc && i < HIST_N; i++) begin
      if (i >= 0 && (smp ? hist_sce[i] : hist_ce[i]) === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic int count_pulses(input int lo, input int hi, input bit smp);
    int n = 0;
    for (int i = lo + 1; i <= hi && i < cyc; i++) begin
      if ((smp ? hist_sce[i] : hist_ce[i]) === 1'b1) n++;
    end
    return n;
  endfunction

  function automatic logic h_rst(input int i);
    return (i >= 0 && i < HIST_N) ? hist_rst[i] : 1'bx;
  endfunction

  function automatic logic h_ce(input int i);
    return (i >= 0 && i < HIST_N) ? hist_ce[i] : 1'bx;
  endfunction

  initial begin
    int t1, t2, t3, t4, t5, found, rel2;
    bus.en = 1'b0; bus.sel_ntsc = 1'b0; bus.soft_rst = 1'b0;
    rst_in = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    exp_q.push_back(model_out());

    // PAL start-up: release at cyc 0, ticks every 4 cycles from cyc 4
    for (int i = 0; i < 41; i++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("first_tick",   next_after(0, 0), 4);
    check_eq("second_tick",  next_after(4, 0), 8);
    check_eq("rst_before",   h_rst(7), 1'b1);
    check_eq("rst_release",  h_rst(8), 1'b0);
    check_eq("no_sce_hold",  count_pulses(0, 8, 1), 0);
    check_eq("first_sample", next_after(8, 1), 20);
    check_eq("second_sample", next_after(20, 1), 32);

    // NTSC select at cyc 41; the PAL period ending at 44 is untouched
    for (int i = 0; i < 39; i++) cycle(1'b1, 1'b1, 1'b0);
    check_eq("pal_last_tick", next_after(40, 0), 44);
    check_eq("ntsc_pre",      hist_ntsc[43], 1'b0);
    check_eq("ntsc_rise",     hist_ntsc[44], 1'b1);
    check_eq("ntsc_first",    next_after(44, 0), 47);
    // 3,3,2 pattern: 3 ticks per 8 cycles, so 9 in 24
    check_eq("ntsc_rate",     count_pulses(44, 68, 0), 9);

    // en low for cyc 80..89; acc holds at 128, two adds left after en returns
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
    check_eq("gap_no_ce",   count_pulses(80, 91, 0), 0);
    check_eq("gap_no_sce",  count_pulses(80, 91, 1), 0);
    check_eq("gap_resume",  next_after(90, 0), 92);

    // soft reset from RUN
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 29; i++) cycle(1'b1, 1'b1, 1'b0);
    check_eq("soft_pre",  h_rst(100), 1'b0);
    check_eq("soft_hold", h_rst(101), 1'b1);
    t1 = next_after(101, 0);
    t2 = next_after(t1, 0);
    t3 = next_after(t2, 0);
    t4 = next_after(t3, 0);
    t5 = next_after(t4, 0);
    check_eq("soft_t1_hold",   h_rst(t1), 1'b1);
    check_eq("soft_t2_rel",    h_rst(t2), 1'b0);
    check_eq("soft_no_sce",    count_pulses(100, t2, 1), 0);
    check_eq("soft_sample",    next_after(t2, 1), t5);

    // soft reset landing on the releasing carry keeps sid_rst high
    cycle(1'b1, 1'b1, 1'b1);
    found = -1;
    for (int i = 0; i < 40 && found < 0; i++) begin
      if (m_hold && m_rcnt == RST_TICKS - 1 && (m_acc + m_inc) >= (1 << ACC_W)) begin
        found = cyc;
        cycle(1'b1, 1'b1, 1'b1);
      end else begin
        cycle(1'b1, 1'b1, 1'b0);
      end
    end
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0);
    check_eq("rel_found",    (found >= 0) ? 32'd1 : 32'd0, 32'd1);
    check_eq("rel_tick",     h_ce(found + 1), 1'b1);
    check_eq("rel_rst_stay", h_rst(found + 1), 1'b1);

    // asynchronous reset mid-cycle with NTSC active
    check_eq("pre_async_ntsc", hist_ntsc[cyc-1], 1'b1);
    @(posedge clk_i);
    #2 rst_in = 1'b1;
    #1;
    check_eq("async_ntsc",  bus.ntsc_active, 1'b0);
    check_eq("async_rst",   bus.sid_rst,     1'b1);
    check_eq("async_phi2",  bus.sid_phi2,    1'b0);
    check_eq("async_ce",    bus.sid_ce,      1'b0);
    check_eq("async_sce",   bus.sample_ce,   1'b0);
    exp_q.delete();
    model_reset();
    exp_q.push_back(model_out());
    rel2 = cyc;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0);
    check_eq("rec_pal_tick",  next_after(rel2, 0), rel2 + 4);
    check_eq("rec_ntsc_pre",  hist_ntsc[rel2+3], 1'b0);
    check_eq("rec_ntsc_rise", hist_ntsc[rel2+4], 1'b1);
    check_eq("rec_ntsc_tick", next_after(rel2 + 4, 0), rel2 + 7);

    check_eq("sce_alignment", bad_sce, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
